// File: rtl/sbox_share_sched_if.sv
// Handshake bundle for sbox_share_sched.
// Carries two request/response channels:
//   st_*  : SubNibbles on the 4*ST_NIB-bit round state
//   key_* : SubWord on the 4*KEY_NIB-bit key-schedule word
// Each channel has an in_* valid/ready/data request and an out_* valid/ready/data response.
// slave  : the scheduler side (drives in_ready, out_valid, out_data)
// master : the requester side (drives in_valid, in_data, out_ready)
interface sbox_share_sched_if #(
    parameter int unsigned ST_NIB  = 16,
    parameter int unsigned KEY_NIB = 4
);
    logic                   st_in_valid;
    logic                   st_in_ready;
    logic [4*ST_NIB-1:0]    st_in_data;
    logic                   st_out_valid;
    logic                   st_out_ready;
    logic [4*ST_NIB-1:0]    st_out_data;

    logic                   key_in_valid;
    logic                   key_in_ready;
    logic [4*KEY_NIB-1:0]   key_in_data;
    logic                   key_out_valid;
    logic                   key_out_ready;
    logic [4*KEY_NIB-1:0]   key_out_data;

    modport slave (
        input  st_in_valid, st_in_data, st_out_ready,
        input  key_in_valid, key_in_data, key_out_ready,
        output st_in_ready, st_out_valid, st_out_data,
        output key_in_ready, key_out_valid, key_out_data
    );

    modport master (
        output st_in_valid, st_in_data, st_out_ready,
        output key_in_valid, key_in_data, key_out_ready,
        input  st_in_ready, st_out_valid, st_out_data,
        input  key_in_ready, key_out_valid, key_out_data
    );
endinterface

// File: rtl/sbox_share_sched.sv
// Nibble-serial substitution scheduler for the small-scale (4-bit) AES core.
// A single 4-bit S-box (GF(2^4) inversion + affine map) is shared between a
// state job (SubNibbles, ST_NIB nibbles) and a key job (SubWord, KEY_NIB
// nibbles). Jobs are granted whole in IDLE and substituted one nibble per clock.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : sbox_share_sched_if.slave, request/response handshakes for both paths
//   busy : high whenever the FSM is outside IDLE
module sbox_share_sched #(
    parameter int unsigned ST_NIB  = 16,
    parameter int unsigned KEY_NIB = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sbox_share_sched_if.slave    bus,
    output logic                 busy
);
    localparam int unsigned SW = 4 * ST_NIB;
    localparam int unsigned KW = 4 * KEY_NIB;
    localparam int unsigned CW = (ST_NIB > 1) ? $clog2(ST_NIB) : 1;
    localparam logic [CW-1:0] LAST_ST  = CW'(ST_NIB - 1);
    localparam logic [CW-1:0] LAST_KEY = CW'(KEY_NIB - 1);
    localparam logic RR_KEY = 1'b1;
    localparam logic RR_ST  = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        RUN_ST,
        RUN_KEY,
        DONE_ST,
        DONE_KEY
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rr_q, rr_d;
    logic [SW-1:0]   work_q, work_d, work_upd;
    logic [SW-1:0]   st_out_q, st_out_d;
    logic [KW-1:0]   key_out_q, key_out_d;
    logic            grant_st, grant_key, idle;
    logic            st_acc, key_acc;
    logic [CW+1:0]   nib_idx;
    logic [3:0]      sbox_in, sbox_out;

    // GF(2^4) multiply modulo x^4 + x + 1
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] aa;
        acc = 4'h0;
        aa  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    // Inverse as x^14 = x^8 * x^4 * x^2; maps 0 to 0
    function automatic logic [3:0] gf_inv(input logic [3:0] x);
        logic [3:0] x2, x4, x8;
        x2 = gf_mul(x, x);
        x4 = gf_mul(x2, x2);
        x8 = gf_mul(x4, x4);
        return gf_mul(gf_mul(x8, x4), x2);
    endfunction

    // Affine map: columns D,B,7,E for input bits 0..3, constant 6
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] b;
        b = gf_inv(x);
        return (b[0] ? 4'hD : 4'h0) ^ (b[1] ? 4'hB : 4'h0) ^
               (b[2] ? 4'h7 : 4'h0) ^ (b[3] ? 4'hE : 4'h0) ^ 4'h6;
    endfunction

    // The one shared S-box, fed by the nibble cnt points at
    assign nib_idx  = {cnt_q, 2'b00};
    assign sbox_in  = work_q[nib_idx +: 4];
    assign sbox_out = sbox(sbox_in);

    // Round-robin grant; only meaningful while idle
    assign idle      = (state_q == IDLE);
    assign grant_st  = bus.st_in_valid  & (~bus.key_in_valid | (rr_q == RR_ST));
    assign grant_key = bus.key_in_valid & (~bus.st_in_valid  | (rr_q == RR_KEY));
    assign st_acc    = idle & grant_st;
    assign key_acc   = idle & grant_key;

    assign bus.st_in_ready   = st_acc  & ~rst;
    assign bus.key_in_ready  = key_acc & ~rst;
    assign bus.st_out_valid  = (state_q == DONE_ST)  & ~rst;
    assign bus.key_out_valid = (state_q == DONE_KEY) & ~rst;
    assign bus.st_out_data   = st_out_q;
    assign bus.key_out_data  = key_out_q;
    assign busy              = ~idle & ~rst;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_q      <= RR_KEY;
            work_q    <= '0;
            st_out_q  <= '0;
            key_out_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            work_q    <= work_d;
            st_out_q  <= st_out_d;
            key_out_q <= key_out_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        work_d    = work_q;
        st_out_d  = st_out_q;
        key_out_d = key_out_q;
        work_upd  = work_q;
        work_upd[nib_idx +: 4] = sbox_out;

        case (state_q)
            IDLE: begin
                if (st_acc) begin
                    work_d  = bus.st_in_data;
                    cnt_d   = '0;
                    rr_d    = RR_KEY;
                    state_d = RUN_ST;
                end else if (key_acc) begin
                    work_d  = SW'(bus.key_in_data);
                    cnt_d   = '0;
                    rr_d    = RR_ST;
                    state_d = RUN_KEY;
                end
            end
            RUN_ST: begin
                work_d = work_upd;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_ST) begin
                    // Result is latched here so it survives the next job's load
                    st_out_d = work_upd;
                    cnt_d    = '0;
                    state_d  = DONE_ST;
                end
            end
            RUN_KEY: begin
                work_d = work_upd;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_KEY) begin
                    key_out_d = work_upd[KW-1:0];
                    cnt_d     = '0;
                    state_d   = DONE_KEY;
                end
            end
            DONE_ST: begin
                if (bus.st_out_ready) state_d = IDLE;
            end
            DONE_KEY: begin
                if (bus.key_out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sbox_share_sched.sv
// Bench for sbox_share_sched: directed scenarios plus randomized traffic,
// checked by a scoreboard fed at acceptance and drained by a monitor.
module tb_sbox_share_sched;
    localparam int unsigned ST_NIB  = 16;
    localparam int unsigned KEY_NIB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    sbox_share_sched_if #(.ST_NIB(ST_NIB), .KEY_NIB(KEY_NIB)) bus();

    sbox_share_sched #(.ST_NIB(ST_NIB), .KEY_NIB(KEY_NIB)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] data;
        int          acc;
    } exp_t;

    exp_t st_q[$];
    exp_t key_q[$];

    bit hold_st  = 1'b0;
    bit rand_rdy = 1'b0;

    logic [3:0] sbox_tbl [16] = '{4'h6, 4'hB, 4'h5, 4'h4, 4'h2, 4'hE, 4'h7, 4'hA,
                                  4'h9, 4'hD, 4'hF, 4'hC, 4'h3, 4'h1, 4'h0, 4'h8};

    // Reference: substitute the low n nibbles through the lookup table
    function automatic logic [63:0] sub_nibs(input logic [63:0] d, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[4*i +: 4] = sbox_tbl[d[4*i +: 4]];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output-ready driver
    initial begin
        bus.st_out_ready  = 1'b1;
        bus.key_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.st_out_ready  = hold_st ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            bus.key_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Issue a state job; gives up after giveup+1 looks at ready
    task automatic send_st(input logic [63:0] d, input int giveup, input bit rnd_data,
                           input bit must, output int acc_cyc);
        exp_t e;
        bit   acc;
        acc     = 1'b0;
        acc_cyc = -1;
        @(posedge clk);
        #1;
        bus.st_in_valid = 1'b1;
        bus.st_in_data  = d;
        for (int n = 0; n <= giveup; n++) begin
            @(negedge clk);
            if (bus.st_in_ready) begin
                e.data  = sub_nibs(bus.st_in_data, ST_NIB);
                e.acc   = cyc;
                acc_cyc = cyc;
                st_q.push_back(e);
                acc = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd_data) bus.st_in_data = {$urandom, $urandom};
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end
        bus.st_in_valid = 1'b0;
        bus.st_in_data  = {$urandom, $urandom};
        if (must) check("st_accept", 64'(acc), 64'd1);
    endtask

    task automatic send_key(input logic [15:0] d, input int giveup, input bit rnd_data,
                            input bit must, output int acc_cyc);
        exp_t e;
        bit   acc;
        acc     = 1'b0;
        acc_cyc = -1;
        @(posedge clk);
        #1;
        bus.key_in_valid = 1'b1;
        bus.key_in_data  = d;
        for (int n = 0; n <= giveup; n++) begin
            @(negedge clk);
            if (bus.key_in_ready) begin
                e.data  = sub_nibs({48'h0, bus.key_in_data}, KEY_NIB);
                e.acc   = cyc;
                acc_cyc = cyc;
                key_q.push_back(e);
                acc = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (rnd_data) bus.key_in_data = 16'($urandom);
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end
        bus.key_in_valid = 1'b0;
        bus.key_in_data  = 16'($urandom);
        if (must) check("key_accept", 64'(acc), 64'd1);
    endtask

    // Monitor: latency on valid rise, data on handshake, ready invariants
    initial begin
        exp_t e;
        bit st_prev;
        bit key_prev;
        st_prev  = 1'b0;
        key_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                st_prev  = 1'b0;
                key_prev = 1'b0;
            end else begin
                check("ready_excl", 64'(bus.st_in_ready & bus.key_in_ready), 64'd0);
                if (busy) check("ready_while_busy", 64'({bus.st_in_ready, bus.key_in_ready}), 64'd0);
                if (bus.st_out_valid && !st_prev && st_q.size() > 0)
                    check("st_latency", 64'(cyc - st_q[0].acc), 64'(ST_NIB + 1));
                if (bus.key_out_valid && !key_prev && key_q.size() > 0)
                    check("key_latency", 64'(cyc - key_q[0].acc), 64'(KEY_NIB + 1));
                if (bus.st_out_valid && bus.st_out_ready) begin
                    if (st_q.size() == 0) begin
                        check("st_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = st_q.pop_front();
                        check("st_data", bus.st_out_data, e.data);
                    end
                end
                if (bus.key_out_valid && bus.key_out_ready) begin
                    if (key_q.size() == 0) begin
                        check("key_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = key_q.pop_front();
                        check("key_data", 64'(bus.key_out_data), e.data);
                    end
                end
                st_prev  = bus.st_out_valid;
                key_prev = bus.key_out_valid;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        st_q.delete();
        key_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (st_q.size() == 0 && key_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        int a_st, a_k1, a_k2, bc, vcnt;
        logic [63:0] held;
        bit seen;

        bus.st_in_valid  = 1'b1;
        bus.key_in_valid = 1'b1;
        bus.st_in_data   = 64'h0123456789ABCDEF;
        bus.key_in_data  = 16'h0123;

        // Reset with both requests asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_st_ready",  64'(bus.st_in_ready), 64'd0);
        check("rst_key_ready", 64'(bus.key_in_ready), 64'd0);
        check("rst_busy",      64'(busy), 64'd0);
        @(posedge clk);
        #1;
        bus.st_in_valid  = 1'b0;
        bus.key_in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("init_st_valid",  64'(bus.st_out_valid), 64'd0);
        check("init_key_valid", 64'(bus.key_out_valid), 64'd0);
        check("init_st_data",   bus.st_out_data, 64'd0);
        check("init_key_data",  64'(bus.key_out_data), 64'd0);
        check("init_busy",      64'(busy), 64'd0);

        // All-zero state: busy cycles 1..17, result all sixes
        send_st(64'h0, 200, 1'b0, 1'b1, a_st);
        bc   = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.st_out_valid) begin
                seen = 1'b1;
                check("st_zero", bus.st_out_data, 64'h6666666666666666);
            end
            if (busy) bc++;
            else break;
        end
        check("busy_cycles", 64'(bc), 64'd17);
        check("st_zero_seen", 64'(seen), 64'd1);

        // Counting pattern on both paths
        send_st(64'h0123456789ABCDEF, 200, 1'b0, 1'b1, a_st);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.st_out_valid) begin
                seen = 1'b1;
                check("st_count", bus.st_out_data, 64'h6B542E7A9DFC3108);
            end
        end
        check("st_count_seen", 64'(seen), 64'd1);
        send_key(16'h0123, 200, 1'b0, 1'b1, a_k1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.key_out_valid) begin
                seen = 1'b1;
                check("key_count", 64'(bus.key_out_data), 64'h6B54);
            end
        end
        check("key_count_seen", 64'(seen), 64'd1);
        drain("drain_directed");

        // Contention right after reset: key, then state, then key again
        do_reset();
        fork
            begin
                send_key(16'hBEEF, 200, 1'b0, 1'b1, a_k1);
                send_key(16'h1234, 200, 1'b0, 1'b1, a_k2);
            end
            send_st(64'hFEDCBA9876543210, 200, 1'b0, 1'b1, a_st);
        join
        check("rr_st_after_key", 64'(a_st - a_k1), 64'd6);
        check("rr_key_after_st", 64'(a_k2 - a_st), 64'd18);
        drain("drain_rr");

        // Backpressure on the state result with a key request waiting
        hold_st = 1'b1;
        fork
            send_st({$urandom, $urandom}, 200, 1'b0, 1'b1, a_st);
            begin
                repeat (3) @(posedge clk);
                send_key(16'($urandom), 200, 1'b0, 1'b1, a_k1);
            end
            begin
                seen = 1'b0;
                for (int i = 0; i < 40 && !seen; i++) begin
                    @(negedge clk);
                    seen = bus.st_out_valid;
                end
                check("bp_valid_seen", 64'(seen), 64'd1);
                held = bus.st_out_data;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("bp_valid_hold", 64'(bus.st_out_valid), 64'd1);
                    check("bp_data_hold",  bus.st_out_data, held);
                    check("bp_key_ready",  64'(bus.key_in_ready), 64'd0);
                end
                hold_st = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("bp_idle_busy",  64'(busy), 64'd0);
                check("bp_idle_key_ready", 64'(bus.key_in_ready), 64'd1);
            end
        join
        drain("drain_bp");

        // Reset in cycle 8 of a state job
        send_st({$urandom, $urandom}, 200, 1'b0, 1'b1, a_st);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",     64'(busy), 64'd0);
        check("mid_rst_st_valid", 64'(bus.st_out_valid), 64'd0);
        st_q.delete();
        key_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_st_valid", 64'(bus.st_out_valid), 64'd0);
        check("post_rst_st_data",  bus.st_out_data, 64'd0);
        check("post_rst_key_data", 64'(bus.key_out_data), 64'd0);
        check("post_rst_busy",     64'(busy), 64'd0);
        vcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.st_out_valid) vcnt++;
        end
        check("aborted_no_valid", 64'(vcnt), 64'd0);
        send_st({$urandom, $urandom}, 200, 1'b0, 1'b1, a_st);
        drain("drain_fresh");

        // Randomized mixed traffic, random out_ready, some abandoned requests
        rand_rdy = 1'b1;
        fork
            for (int j = 0; j < 30; j++) begin
                int g, ac;
                g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 300;
                send_st({$urandom, $urandom}, g, 1'b1, g == 300, ac);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            for (int j = 0; j < 30; j++) begin
                int g, ac;
                g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 300;
                send_key(16'($urandom), g, 1'b1, g == 300, ac);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        join
        drain("drain_random");
        rand_rdy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
- Nibble-serial substitution scheduler for the small-scale AES (4-bit nibble) core.
- Instantiates exactly one combinational 4-bit S-box: GF(2^4) inversion followed by the affine map.
- Shares that S-box between two requesters:
  - state path: SubNibbles on the 64-bit round state;
  - key path: SubWord on a 16-bit key-schedule word.
- One nibble is substituted per clock. Jobs are arbitrated whole; a granted job runs to completion.

Parameters:
ST_NIB, 16, nibbles per state job (state width = 4*ST_NIB)
KEY_NIB, 4, nibbles per key job (key width = 4*KEY_NIB)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
st_in_valid  in  1  state job request
st_in_ready  out  1  state job accepted when valid&ready
st_in_data  in  4*ST_NIB  state to substitute
st_out_valid  out  1  state result available
st_out_ready  in  1  state result consumed when valid&ready
st_out_data  out  4*ST_NIB  substituted state
key_in_valid  in  1  key job request
key_in_ready  out  1  key job accepted when valid&ready
key_in_data  in  4*KEY_NIB  key word to substitute
key_out_valid  out  1  key result available
key_out_ready  in  1  key result consumed
key_out_data  out  4*KEY_NIB  substituted key word
busy  out  1  high in any state except IDLE

Behaviour:
- S-box function S(x), x = 0..F: 6,B,5,4,2,E,7,A,9,D,F,C,3,1,0,8.
- Exactly one S-box instance exists. The S-box input is mux-selected from the working register nibble indexed by cnt.
- FSM states: IDLE, RUN_ST, RUN_KEY, DONE_ST, DONE_KEY.
- Grant, evaluated combinationally in IDLE only:
  - If only one requester is valid, that requester wins.
  - If both are valid, the winner is the one not served last, tracked by a round-robin flag rr.
  - rr resets to "key wins next".
- Ready rules:
  - x_in_ready = (state==IDLE) & grant_x. It is never high outside IDLE.
  - Both readys are never high in the same cycle.
- Accept on valid&ready (cycle 0):
  - working register ← in_data, zero-extended to 64 bits for key jobs.
  - cnt ← 0.
  - Move to RUN_x.
  - rr updates to favour the other requester.
- RUN_x, one cycle per nibble:
  - nibble[cnt] ← S(nibble[cnt]), nibble 0 = bits [3:0] first.
  - cnt increments.
  - After nibble N-1 (N = ST_NIB or KEY_NIB), move to DONE_x.
- Latency from accept cycle to out_valid: ST_NIB+1 cycles for state (17), KEY_NIB+1 for key (5).
- DONE_x:
  - x_out_valid=1 and x_out_data = working register (low 4*KEY_NIB bits for key).
  - Both are held stable until x_out_ready.
  - On handshake, go to IDLE the next cycle.
  - No new job is accepted in the handshake cycle: one bubble.
- out_data is registered. It keeps its last value after handshake and is valid only with out_valid.
- In_data changes while the block is not ready are ignored. Input data is sampled only at acceptance.
- Valid deasserted mid-wait: no acceptance. No state is retained from that request.
- A requester asserting in_valid during the other requester's job waits. It is served at the next IDLE; round-robin guarantees no starvation.
- Reset, including mid-RUN or mid-DONE:
  - Aborts the job; no result is delivered.
  - Next cycle: state=IDLE, cnt=0, rr=key-first, working register=0.
  - Reset output values: all out_valid=0, all out_data=0, in_readys=0 during reset, busy=0.
- cnt width is ceil(log2(ST_NIB)). It does not wrap within a job.

Test Plan:
- Reset, then st_in_data=0x0000000000000000 accepted at cycle 0 → st_out_valid rises cycle 17, st_out_data=0x6666666666666666; busy high cycles 1-17.
- st_in_data=0x0123456789ABCDEF → st_out_data=0x6B542E7A9DFC3108; key readys low throughout.
- key_in_data=0x0123 → key_out_valid at cycle 5, key_out_data=0x6B54.
- Both valid in the same cycle after reset:
  - key accepted first; key_out_valid cycle 5 with out_ready=1;
  - state accepted cycle 6; st_out_valid cycle 23;
  - next simultaneous request grants state first.
- Backpressure: hold st_out_ready=0 for 10 cycles in DONE_ST → st_out_valid and data stable, key_in_ready=0 throughout; release → IDLE next cycle.
- Assert rst at cycle 8 of a state job → outputs 0, no st_out_valid. A fresh job after reset produces the correct result at +17.
